// File: rtl/data_mem_responder.sv
// Data-memory responder: decodes CPU accesses to word RAM or the I/O page
// (LED register, keyboard scan-code FIFO, free-running cycle counter).
module data_mem_responder #(
    parameter int unsigned RAM_AW    = 10,
    parameter int unsigned FIFO_AW   = 3,
    parameter logic [15:0] MMIO_PAGE = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        wren,
    output logic [31:0] mem_read_data,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic [15:0] led,
    output logic        kbd_nonempty
);

    localparam int unsigned FifoDepth = 2 ** FIFO_AW;
    localparam int unsigned CntW      = FIFO_AW + 1;

    logic [31:0]        ram [2 ** RAM_AW];
    logic [7:0]         fifo_mem [FifoDepth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        cycle_q;
    logic [15:0]        led_q;
    logic [31:0]        rdata_q, rdata_d;

    logic              is_io;
    logic [RAM_AW-1:0] ram_idx;
    logic [13:0]       io_off;
    logic              wr_led, wr_kstat, wr_kdata, wr_cycle;
    logic              fifo_empty, fifo_full, do_pop, do_push, drop;
    logic [3:0]        kstat_cnt;
    logic [7:0]        kdata;
    logic              unused_addr;

    assign is_io       = (mem_addr[31:16] == MMIO_PAGE);
    assign ram_idx     = mem_addr[RAM_AW+1:2];
    assign io_off      = mem_addr[15:2];
    assign unused_addr = ^mem_addr[1:0];

    assign wr_led   = is_io && wren && (io_off == 14'h0);
    assign wr_kstat = is_io && wren && (io_off == 14'h1);
    assign wr_kdata = is_io && wren && (io_off == 14'h2);
    assign wr_cycle = is_io && wren && (io_off == 14'h3);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FifoDepth));
    assign do_pop     = wr_kdata && !fifo_empty;
    // A pop frees the slot, so a push into a full FIFO is accepted in the same cycle.
    assign do_push    = kbd_valid && (!fifo_full || do_pop);
    assign drop       = kbd_valid && fifo_full && !do_pop;

    always_comb begin
        count_d    = count_q + CntW'(do_push) - CntW'(do_pop);
        overflow_d = overflow_q;
        if (wr_kstat) overflow_d = 1'b0;
        if (drop)     overflow_d = 1'b1;
    end

    assign kstat_cnt    = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
    assign kdata        = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
    assign kbd_nonempty = !fifo_empty;
    assign led          = led_q;
    assign mem_read_data = rdata_q;

    // Read mux uses pre-edge state, giving read-before-write on every target.
    always_comb begin
        rdata_d = '0;
        if (!is_io) begin
            rdata_d = ram[ram_idx];
        end else begin
            case (io_off)
                14'h0:   rdata_d = {16'h0, led_q};
                14'h1:   rdata_d = {24'h0, kstat_cnt, 2'b00, overflow_q, !fifo_empty};
                14'h2:   rdata_d = {24'h0, kdata};
                14'h3:   rdata_d = cycle_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wren && !is_io) ram[ram_idx] <= mem_write_data;
    end

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr_q] <= kbd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            led_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
        end else begin
            rdata_q    <= rdata_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cycle_q    <= wr_cycle ? 32'h0 : cycle_q + 32'h1;
            if (wr_led)  led_q    <= mem_write_data[15:0];
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic, all checked
// against a queue/array reference model of the memory map.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        wren;
    logic [31:0] mem_read_data;
    logic [7:0]  kbd_data;
    logic        kbd_valid;
    logic [15:0] led;
    logic        kbd_nonempty;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ram [1024];
    bit          m_known [1024];
    logic [7:0]  m_q [$];
    logic [15:0] m_led;
    logic        m_ovf;
    logic [31:0] m_cyc;

    data_mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .wren          (wren),
        .mem_read_data (mem_read_data),
        .kbd_data      (kbd_data),
        .kbd_valid     (kbd_valid),
        .led           (led),
        .kbd_nonempty  (kbd_nonempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_led = '0;
        m_ovf = 1'b0;
        m_cyc = '0;
    endtask

    // One clock: drive inputs, predict the read, apply writes to the model, compare.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic kv, input logic [7:0] kd);
        logic [31:0] exp_rd;
        logic        known;
        logic        io;
        int          idx;
        int          cnt;
        mem_addr       = a;
        mem_write_data = d;
        wren           = w;
        kbd_valid      = kv;
        kbd_data       = kd;
        io  = (a[31:16] == 16'hFFFF);
        idx = int'(a[11:2]);
        known = 1'b1;
        cnt = (m_q.size() > 15) ? 15 : m_q.size();
        if (!io) begin
            exp_rd = m_ram[idx];
            known  = m_known[idx];
        end else begin
            case (a[15:2])
                14'h0:   exp_rd = {16'h0, m_led};
                14'h1:   exp_rd = {24'h0, 4'(cnt), 2'b00, m_ovf, m_q.size() != 0};
                14'h2:   exp_rd = (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0;
                14'h3:   exp_rd = m_cyc;
                default: exp_rd = 32'h0;
            endcase
        end
        @(posedge clk);
        if (w && !io) begin
            m_ram[idx]   = d;
            m_known[idx] = 1'b1;
        end
        if (w && io && a[15:2] == 14'h0) m_led = d[15:0];
        if (w && io && a[15:2] == 14'h1) m_ovf = 1'b0;
        if (w && io && a[15:2] == 14'h2 && m_q.size() != 0) void'(m_q.pop_front());
        if (kv) begin
            if (m_q.size() < 8) m_q.push_back(kd);
            else m_ovf = 1'b1;
        end
        m_cyc = (w && io && a[15:2] == 14'h3) ? 32'h0 : m_cyc + 32'h1;
        #1;
        if (known) check("rdata_model", mem_read_data, exp_rd);
        check("led_model", {16'h0, led}, {16'h0, m_led});
        check("nonempty_model", {31'h0, kbd_nonempty}, {31'h0, m_q.size() != 0});
    endtask

    task automatic idle();
        step(32'h10, 32'h0, 1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] push_bytes [9];

    initial begin
        push_bytes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        rst = 1'b1;
        mem_addr = '0; mem_write_data = '0; wren = 1'b0; kbd_valid = 1'b0; kbd_data = '0;
        for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
        model_reset();
        #12;
        check("reset_rdata", mem_read_data, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_nonempty", {31'h0, kbd_nonempty}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // RAM write/read and aliasing
        step(32'h10, 32'h12345678, 1'b1, 1'b0, 8'h00);
        step(32'h10, 32'h0, 1'b0, 1'b0, 8'h00);
        check("ram_read", mem_read_data, 32'h12345678);
        step(32'h1010, 32'h0, 1'b0, 1'b0, 8'h00);
        check("ram_alias", mem_read_data, 32'h12345678);

        // Read-before-write
        step(32'h20, 32'hAAAA5555, 1'b1, 1'b0, 8'h00);
        step(32'h20, 32'h0F0F0F0F, 1'b1, 1'b0, 8'h00);
        check("rbw_old", mem_read_data, 32'hAAAA5555);
        step(32'h20, 32'h0, 1'b0, 1'b0, 8'h00);
        check("rbw_new", mem_read_data, 32'h0F0F0F0F);

        // LED
        step(32'hFFFF0000, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00);
        check("led_write", {16'h0, led}, 32'h0000BEEF);
        step(32'hFFFF0000, 32'h0, 1'b0, 1'b0, 8'h00);
        check("led_read", mem_read_data, 32'h0000BEEF);

        // FIFO order and overflow
        for (int i = 0; i < 9; i++) step(32'h10, 32'h0, 1'b0, 1'b1, push_bytes[i]);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 8'h00);
        check("kstat_full_ovf", mem_read_data, 32'h83);
        step(32'hFFFF0008, 32'h0, 1'b0, 1'b0, 8'h00);
        check("kdata_head", mem_read_data, 32'h1C);
        step(32'hFFFF0008, 32'h0, 1'b1, 1'b0, 8'h00);
        step(32'hFFFF0008, 32'h0, 1'b0, 1'b0, 8'h00);
        check("kdata_after_pop", mem_read_data, 32'h32);
        step(32'hFFFF0004, 32'h0, 1'b1, 1'b0, 8'h00);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 8'h00);
        check("kstat_ovf_clr", mem_read_data, 32'h71);

        // Simultaneous push and pop while full
        step(32'h10, 32'h0, 1'b0, 1'b1, 8'h77);
        step(32'hFFFF0008, 32'h0, 1'b1, 1'b1, 8'h5A);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 8'h00);
        check("kstat_full_pushpop", mem_read_data, 32'h81);
        for (int i = 0; i < 7; i++) step(32'hFFFF0008, 32'h0, 1'b1, 1'b0, 8'h00);
        step(32'hFFFF0008, 32'h0, 1'b0, 1'b0, 8'h00);
        check("kdata_tail", mem_read_data, 32'h5A);
        step(32'hFFFF0008, 32'h0, 1'b1, 1'b0, 8'h00);
        step(32'hFFFF0008, 32'h0, 1'b1, 1'b0, 8'h00);
        check("kdata_empty_pop", mem_read_data, 32'h0);
        check("fifo_drained", {31'h0, kbd_nonempty}, 32'h0);

        // Cycle counter
        for (int i = 0; i < 5; i++) idle();
        step(32'hFFFF000C, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h00);
        step(32'hFFFF000C, 32'h0, 1'b0, 1'b0, 8'h00);
        check("cycle_after_clear", mem_read_data, 32'h0);
        step(32'hFFFF000C, 32'h0, 1'b0, 1'b0, 8'h00);
        check("cycle_count", mem_read_data, 32'h1);

        // Mid-run reset
        step(32'hFFFF0000, 32'h1234, 1'b1, 1'b1, 8'h11);
        step(32'hFFFF000C, 32'h0, 1'b0, 1'b1, 8'h22);
        rst = 1'b1;
        #2;
        check("midrst_rdata", mem_read_data, 32'h0);
        check("midrst_led", {16'h0, led}, 32'h0);
        check("midrst_nonempty", {31'h0, kbd_nonempty}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(32'hFFFF000C, 32'h0, 1'b0, 1'b0, 8'h00);
        check("postrst_cycle", mem_read_data, 32'h0);
        step(32'hFFFF0004, 32'h0, 1'b0, 1'b0, 8'h00);
        check("postrst_kstat", mem_read_data, 32'h0);
        step(32'h20, 32'h0, 1'b0, 1'b0, 8'h00);
        check("ram_survives_rst", mem_read_data, 32'h0F0F0F0F);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [15:0] hi;
            if ($urandom_range(0, 1) == 0) begin
                hi = 16'($urandom_range(0, 16'hFFFE));
                a  = {hi, 4'($urandom), 6'h0, 4'($urandom), 2'($urandom)};
            end else begin
                a = {16'hFFFF, 10'h0, 4'($urandom_range(0, 4)), 2'($urandom)};
            end
            step(a, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 4),
                 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the CPU data-memory interface (mem_addr / mem_write_data / wren / mem_read_data).
- Decodes each CPU access to one of two targets: on-chip word RAM, or a small memory-mapped I/O page.
- The I/O page holds an LED register, a keyboard scan-code FIFO and a free-running cycle counter.
- Sits between the CPU and board I/O in the top level.

Parameters:
- RAM_AW, 10, RAM word-address width (2^RAM_AW 32-bit words).
- FIFO_AW, 3, keyboard FIFO address width (depth 2^FIFO_AW = 8).
- MMIO_PAGE, 16'hFFFF, value of mem_addr[31:16] that selects the I/O page.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  in  32  byte address from CPU; bits [1:0] ignored (word access).
- mem_write_data  in  32  write data from CPU.
- wren  in  1  1 = write this cycle, 0 = read.
- mem_read_data  out  32  registered read data, word-aligned.
- kbd_data  in  8  scan code from keyboard receiver.
- kbd_valid  in  1  one-cycle strobe: kbd_data is valid.
- led  out  16  LED register.
- kbd_nonempty  out  1  FIFO holds at least one entry.

Behaviour:
- Reset (async, rst=1) forces:
  - mem_read_data=0, led=0.
  - FIFO empty (pointers=0, count=0), kbd_nonempty=0.
  - overflow flag=0, cycle counter=0.
  - RAM contents are not reset.
- Decode:
  - mem_addr[31:16]!=MMIO_PAGE -> RAM, word index = mem_addr[RAM_AW+1:2]. Higher address bits are ignored, so the RAM aliases across the space.
  - mem_addr[31:16]==MMIO_PAGE -> I/O; register offset = mem_addr[15:0] with bits [1:0] ignored.
- I/O map:
  - 0x0000 LED: R/W; write stores mem_write_data[15:0]; read returns {16'h0, led}.
  - 0x0004 KSTAT: read returns {24'h0, count[3:0], 2'b0, overflow, nonempty}; any write clears overflow.
  - 0x0008 KDATA: read returns {24'h0, head byte}, or 0 when empty; reads never pop. Any write pops one entry; a write when empty is ignored.
  - 0x000C CYCLE: read returns counter; any write loads 0.
  - Any other offset: read 0, write ignored.
- Read timing:
  - One-cycle latency: mem_read_data at edge N+1 reflects mem_addr at edge N.
  - mem_read_data is updated every cycle, including write cycles. During a write it returns the old contents of the addressed location (read-before-write).
- Write timing: committed at the rising edge when wren=1; visible to a read of the same address one cycle later.
- FIFO:
  - Push when kbd_valid=1 and not full.
  - kbd_valid=1 while full and no same-cycle pop: byte dropped, overflow set (sticky until cleared via KSTAT).
  - Push and pop in the same cycle:
    - full: pop head then push; count unchanged; no overflow.
    - empty: push only (pop ignored).
    - otherwise: count unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
  - count is FIFO_AW+1 bits; the KSTAT field saturates display at 15.
  - KSTAT write that clears overflow, coinciding with a dropped push: overflow is set (set wins).
- Cycle counter:
  - Increments every cycle, wrapping 32'hFFFFFFFF -> 0.
  - A write loads 0 at that edge and resumes counting from there.
  - A read returns the pre-edge value.
- kbd_nonempty: combinational from count!=0.
- Reset asserted mid-operation clears all state immediately; the first access after release behaves as if following power-up.

Test Plan:
- RAM write then read: write 0x12345678 to 0x00000010, then read 0x00000010 -> mem_read_data=0x12345678 one cycle after the read address. Read 0x00001010 (alias, RAM_AW=10) -> same value.
- Read-before-write: with RAM[0x20]=0xAAAA5555, a cycle with wren=1 at addr 0x20 and data 0x0F0F0F0F -> mem_read_data=0xAAAA5555. A read of 0x20 on the next cycle -> 0x0F0F0F0F.
- LED: write 0xDEADBEEF to 0xFFFF0000 -> led=16'hBEEF. Read 0xFFFF0000 -> 0x0000BEEF.
- FIFO order and overflow: push 0x1C,0x32,…, 9 bytes total.
  - KSTAT -> 0x83 (count 8, overflow, nonempty).
  - KDATA read -> 0x1C; KDATA write then read -> 0x32.
  - KSTAT write -> overflow=0.
- FIFO simultaneous push and pop when full: with count=8, kbd_valid=1 (kbd_data=0x5A) and KDATA write in the same cycle -> count stays 8, overflow stays 0, 0x5A becomes the tail.
- Counter and reset: let the counter run, write 0xFFFF000C, read back -> 1 one cycle later. Assert rst mid-run -> counter=0, led=0, FIFO empty, mem_read_data=0.
